// File: rtl/hex_scan_driver.sv
// hex_scan_driver: multiplexes a 16-bit value onto a four-digit seven-segment
// display. Digit 0 (leftmost, anodes[3]) shows data[15:12]; digit 3
// (anodes[0]) shows data[3:0]. data is latched into a shadow register only at
// the frame boundary, so a displayed frame never mixes old and new values.
// Each digit slot lasts SCAN_DIV cycles. The first BLANK_CYCLES cycles of a
// slot keep every digit dark so the previous digit does not ghost.
// Optional build macro HEX_SCAN_LZB_EN enables leading-zero blanking.
// Digits left of the first nonzero nibble stay dark. Digit 3 is always shown.
module hex_scan_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] data,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic        frame_start
);

  localparam int             CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);

  // Segment pattern {A,B,C,D,E,F,G} for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic          wrap, frame_edge;
  logic [3:0]    nibble_nxt;
  logic          digit_blank;
  logic          dark_nxt;
  logic [3:0]    anodes_nxt;
  logic [6:0]    segments_nxt;

`ifdef HEX_SCAN_LZB_EN
  // Bit i is set when digit i is a leading zero. Bit 3 is always clear
  // because the last digit must show even for 0x0000.
  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    logic [3:0] m;
    m[0] = (v[15:12] == 4'h0);
    m[1] = m[0] && (v[11:8] == 4'h0);
    m[2] = m[1] && (v[7:4] == 4'h0);
    m[3] = 1'b0;
    return m;
  endfunction

  logic [3:0] lzb, lzb_nxt;
`endif

  // Next-state and next-output computation. Outputs are registered from this
  // result so they always line up with the state that is being entered.
  always_comb begin
    // NOTE: every signal gets a value on every path so no latch is inferred.
    wrap       = (cnt == CNT_MAX);
    frame_edge = wrap && (idx == 2'd3);
    cnt_nxt    = wrap ? '0 : cnt + CW'(1);
    idx_nxt    = wrap ? idx + 2'd1 : idx;
    shadow_nxt = frame_edge ? data : shadow;

    case (idx_nxt)
      2'd0:    nibble_nxt = shadow_nxt[15:12];
      2'd1:    nibble_nxt = shadow_nxt[11:8];
      2'd2:    nibble_nxt = shadow_nxt[7:4];
      default: nibble_nxt = shadow_nxt[3:0];
    endcase

`ifdef HEX_SCAN_LZB_EN
    lzb_nxt     = frame_edge ? lz_mask(data) : lzb;
    digit_blank = lzb_nxt[idx_nxt];
`else
    digit_blank = 1'b0;
`endif

    dark_nxt     = (int'(cnt_nxt) < BLANK_CYCLES) || digit_blank;
    anodes_nxt   = dark_nxt ? 4'b0000 : (4'b1000 >> idx_nxt);
    segments_nxt = dark_nxt ? 7'b0000000 : glyph(nibble_nxt);
  end

  // Scan state, shadow latch and registered display outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: non-blocking assignments keep every register updating from
      // the values sampled before the edge.
      cnt         <= '0;
      idx         <= 2'd0;
      shadow      <= 16'h0000;
      anodes      <= 4'b0000;
      segments    <= 7'b0000000;
      frame_start <= 1'b0;
`ifdef HEX_SCAN_LZB_EN
      lzb         <= 4'b0111;
`endif
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shadow      <= shadow_nxt;
      anodes      <= anodes_nxt;
      segments    <= segments_nxt;
      frame_start <= frame_edge;
`ifdef HEX_SCAN_LZB_EN
      lzb         <= lzb_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with SCAN_DIV=4 and BLANK_CYCLES=1.
// A frame is 16 cycles. Slot k of a frame has cnt=k%4 and idx=k/4.
// Expected outputs come from the glyph table written out below.
module tb_hex_scan_driver;

  localparam int SD = 4;
  localparam int BC = 1;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  hex_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .data       (data),
    .anodes     (anodes),
    .segments   (segments),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return tab[n];
  endfunction

  // Checks slots 0..nk-1 of a frame showing val. The check at slot 0 expects
  // frame_start = fs0. At slot 8, data is set to nxt. The task returns one
  // negedge into slot nk.
  task automatic check_frame(input logic [15:0] val, input logic fs0,
                             input logic [15:0] nxt, input int nk);
    for (int k = 0; k < nk; k++) begin
      int         c;
      int         d;
      logic [3:0] nib;
      logic       blank;
      logic [3:0] exp_an;
      logic [6:0] exp_sg;
      c   = k % SD;
      d   = k / SD;
      nib = 4'((val >> (12 - 4 * d)) & 16'hF);
      blank = (c < BC);
`ifdef HEX_SCAN_LZB_EN
      if (d < 3 && (val >> (12 - 4 * d)) == 16'h0) blank = 1'b1;
`endif
      exp_an = blank ? 4'b0000 : 4'(4'b1000 >> d);
      exp_sg = blank ? 7'b0 : ref_glyph(nib);
      #1;
      check($sformatf("anodes %h k%0d", val, k), 32'(anodes), 32'(exp_an));
      check($sformatf("segments %h k%0d", val, k), 32'(segments), 32'(exp_sg));
      check($sformatf("frame_start %h k%0d", val, k), 32'(frame_start),
            32'((k == 0) ? fs0 : 1'b0));
      check($sformatf("onehot %h k%0d", val, k), 32'($countones(anodes) <= 1), 32'd1);
      if (k == 8) data = nxt;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // Hold reset and toggle data. The outputs must stay at zero.
    rst_n = 1'b0;
    data  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data = ~data;
      #1;
      check($sformatf("rst anodes %0d", i), 32'(anodes), 32'd0);
      check($sformatf("rst segments %0d", i), 32'(segments), 32'd0);
      check($sformatf("rst frame_start %0d", i), 32'(frame_start), 32'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    data  = 16'h5555;
    // The first frame shows 0000 and has no frame_start pulse.
    check_frame(16'h0000, 1'b0, 16'h1234, 16);
    check_frame(16'h1234, 1'b1, 16'hABCD, 16);
    // data changes mid-frame. The current frame must keep showing ABCD.
    check_frame(16'hABCD, 1'b1, 16'h0F00, 16);
    check_frame(16'h0F00, 1'b1, 16'h0123, 16);
    check_frame(16'h0123, 1'b1, 16'h4567, 16);
    check_frame(16'h4567, 1'b1, 16'h89AB, 16);
    check_frame(16'h89AB, 1'b1, 16'hCDEF, 16);
    check_frame(16'hCDEF, 1'b1, 16'h00A5, 16);
    check_frame(16'h00A5, 1'b1, 16'h0000, 16);
    check_frame(16'h0000, 1'b1, 16'h1234, 16);

    // Assert reset asynchronously during the ON phase of digit 2.
    check_frame(16'h1234, 1'b1, 16'h1234, 9);
    #1;
    check("digit2 on before reset", 32'(anodes), 32'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst anodes", 32'(anodes), 32'd0);
    check("async rst segments", 32'(segments), 32'd0);
    check("async rst frame_start", 32'(frame_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // The scan restarts at digit 0 with an empty shadow.
    check_frame(16'h0000, 1'b0, 16'h1234, 16);
    check_frame(16'h1234, 1'b1, 16'h1234, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Multiplexed driver for the four-digit seven-segment display: takes the 16-bit data bus from the counter stage, latches it once per scan frame, and time-multiplexes the four hex digits onto shared segment lines with one-hot digit enables. Sits directly downstream of the counter; its `anodes`/`segments` outputs feed the board-level inversion and bit mapping at top level.

## Interface
- `SCAN_DIV`, 1000: clock cycles per digit slot; ≥ 2.
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all digit enables off (ghosting guard); 0 ≤ `BLANK_CYCLES` < `SCAN_DIV`.

- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `data`  in  16  value to display; digit 0 (leftmost) = `data[15:12]`, digit 3 = `data[3:0]`.
- `anodes`  out  4  one-hot active-high digit enable; `anodes[3]` = digit 0 … `anodes[0]` = digit 3.
- `segments`  out  7  active-high `{A,B,C,D,E,F,G}`.
- `frame_start`  out  1  one-cycle pulse marking a new frame / shadow reload.

## Operation
- State: slot counter `cnt` (0..`SCAN_DIV`-1), digit index `idx` (0..3), 16-bit `shadow`.
- `cnt` increments every cycle; at `SCAN_DIV`-1 it wraps to 0 and `idx` advances 0→1→2→3→0.
- Frame boundary is the edge on which `cnt`=`SCAN_DIV`-1 and `idx`=3: `shadow` ← `data`, `idx` ← 0, `cnt` ← 0. `data` is sampled only there; changes mid-frame never reach the display (no tearing).
- Slot phases: BLANK while `cnt` < `BLANK_CYCLES` (`anodes`=0, `segments`=0); ON otherwise (`anodes` = one-hot of `idx`, `segments` = glyph of the selected `shadow` nibble). With `BLANK_CYCLES`=0 there is no BLANK phase.
- Glyphs `{A..G}`: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- Outputs are registers, computed from next state, so they always match the current `cnt`/`idx`/`shadow` with no combinational glitches.

## Timing
- Reset (async assert, sync release): `cnt`=0, `idx`=0, `shadow`=0, `anodes`=0, `segments`=0, `frame_start`=0.
- First frame after reset displays 0000; first `data` capture at the end of that frame (4·`SCAN_DIV` cycles after release).
- `frame_start` is high exactly in the cycle after the reload edge (`idx`=0, `cnt`=0); no pulse on reset release.
- Latency `data` → visible: ≤ 4·`SCAN_DIV` + `BLANK_CYCLES` + 1 cycles.
- Frame period exactly 4·`SCAN_DIV` cycles; each digit lit `SCAN_DIV`-`BLANK_CYCLES` cycles per frame.
- Reset asserted mid-frame: all outputs to 0 immediately (asynchronously); restart from the reset state.
- At most one bit of `anodes` is set in any cycle; never two on a slot transition.

## Configuration
- `HEX_SCAN_LZB_EN` defined: leading-zero blanking. At each reload, digits left of the first nonzero nibble are marked blank; in their ON phase `anodes`=0 and `segments`=0. Digit 3 is never blanked (0x0000 shows "0"). Blank mask is computed from `shadow`, stable for the whole frame.
- Not defined: all four digits always shown, including leading zeros.

## Test plan
- Reset: hold `RST_N`=0, toggle `data` → `anodes`=0, `segments`=0, `frame_start`=0; release with `SCAN_DIV`=4, `BLANK_CYCLES`=1 → first frame shows 0000, `frame_start` first pulses 16 cycles after release.
- Scan order/blanking: `data`=16'h1234 after first reload → per 4-cycle slot 1 blank cycle then `anodes`=1000/0110000, 0100/1101101, 0010/1111001, 0001/0110011.
- Tearing: change `data` 16'hABCD→16'h0F00 mid-frame → current frame stays ABCD; next frame shows 0F00.
- All glyphs: sweep `data` through 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF → segments match the glyph list; `anodes` one-hot or zero every cycle.
- `HEX_SCAN_LZB_EN`: `data`=16'h00A5 → digits 0,1 dark, A and 5 shown; `data`=16'h0000 → only digit 3 shows 1111110; without macro 16'h00A5 shows 1111110 on digits 0,1.
- Async reset mid-frame during ON phase of digit 2 → outputs 0 same cycle; after release scan restarts at digit 0 with `shadow`=0.
